// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and signed_op encodings for mult_seq_unit.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic OP_UNSIGNED = 1'b0;
  localparam logic OP_SIGNED = 1'b1;
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth add/sub plus arithmetic right shift of {a,q,q0}.
module booth_step #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  input  logic         q0,
  output logic [N-1:0] a_nxt,
  output logic [N-1:0] q_nxt,
  output logic         q0_nxt
);
  logic [N-1:0] s;
  always_comb begin
    s = ({q[0], q0} == 2'b10) ? a - m : ({q[0], q0} == 2'b01) ? a + m : a;
    {a_nxt, q_nxt, q0_nxt} = {s[N-1], s, q};
  end
endmodule

// File: rtl/mult_seq_unit.sv
// mult_seq_unit: sequential Booth multiplier, WIDTH+1 steps per product.
// Define MULT_ZERO_BYPASS_EN to finish zero-operand multiplies straight from IDLE.
module mult_seq_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf
);
  localparam int N = WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  state_t state;
  logic [N-1:0] a, q, m, a_n, q_n;
  logic q0, q0_n, sgn, ovf_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod;
  logic ext_x, ext_y;
  booth_step #(.N(N)) u_step (
    .a(a), .q(q), .m(m), .q0(q0),
    .a_nxt(a_n), .q_nxt(q_n), .q0_nxt(q0_n)
  );
  // Product sits in the low 2*WIDTH bits of the (WIDTH+1)-bit-per-half {A,Q} pair.
  assign prod = {a_n[WIDTH-2:0], q_n};
  assign ovf_n = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                     : (prod[2*WIDTH-1:WIDTH] != '0);
  assign ext_x = (signed_op == OP_SIGNED) & x[WIDTH-1];
  assign ext_y = (signed_op == OP_SIGNED) & y[WIDTH-1];
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      m <= '0;
      q0 <= 1'b0;
      cnt <= '0;
      sgn <= 1'b0;
      hi <= '0;
      lo <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m <= {ext_x, x};
          q <= {ext_y, y};
          a <= '0;
          q0 <= 1'b0;
          cnt <= CW'(N);
          sgn <= signed_op;
`ifdef MULT_ZERO_BYPASS_EN
          if (x == '0 || y == '0) begin
            hi <= '0;
            lo <= '0;
            ovf <= 1'b0;
            state <= DONE;
          end else state <= CALC;
`else
          state <= CALC;
`endif
        end
        CALC: begin
          a <= a_n;
          q <= q_n;
          q0 <= q0_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
            ovf <= ovf_n;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq_unit.sv
// tb_mult_seq_unit: scoreboard bench for mult_seq_unit (WIDTH=8 and WIDTH=32 instances).
module tb_mult_seq_unit;
  typedef struct {
    logic [63:0] p;
    logic o;
    int lat;
    int t0;
  } exp_t;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 10;
`endif
  logic clk, reset;
  logic start, sop, busy, done, ovf;
  logic [7:0] x, y, hi, lo;
  logic start2, sop2, busy2, done2, ovf2;
  logic [31:0] x2, y2, hi2, lo2;
  exp_t sb[$], sb2[$];
  exp_t e, e2;
  int cmp = 0, err = 0, cyc = 0;

  mult_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(sop), .x(x), .y(y),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .ovf(ovf)
  );
  mult_seq_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start2), .signed_op(sop2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .ovf(ovf2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    cmp++;
    if (act !== exp_v) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) if (done) begin
    if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk("product", 64'({hi, lo}), e.p);
      chk("ovf", 64'(ovf), 64'(e.o));
      chk("latency", 64'(cyc - e.t0), 64'(e.lat - 1));
    end
  end

  always @(negedge clk) if (done2) begin
    if (sb2.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
    else begin
      e2 = sb2.pop_front();
      chk("product32", {hi2, lo2}, e2.p);
      chk("ovf32", 64'(ovf2), 64'(e2.o));
      chk("latency32", 64'(cyc - e2.t0), 64'(e2.lat - 1));
    end
  end

  task automatic launch(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                        input logic [15:0] p, input logic o, input int lat);
    exp_t t;
    @(negedge clk);
    sop = s; x = xv; y = yv; start = 1;
    @(posedge clk);
    #1;
    start = 0; sop = ~s; x = ~xv; y = ~yv;
    t.p = 64'(p); t.o = o; t.lat = lat; t.t0 = cyc;
    sb.push_back(t);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic op(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                    input logic [15:0] p, input logic o, input int lat);
    launch(s, xv, yv, p, o, lat);
    drain();
  endtask

  task automatic op32(input logic s, input logic [31:0] xv, input logic [31:0] yv,
                      input logic [63:0] p, input logic o);
    exp_t t;
    @(negedge clk);
    sop2 = s; x2 = xv; y2 = yv; start2 = 1;
    @(posedge clk);
    #1;
    start2 = 0; x2 = ~xv; y2 = ~yv;
    t.p = p; t.o = o; t.lat = 34; t.t0 = cyc;
    sb2.push_back(t);
    for (int i = 0; i < 200 && sb2.size() != 0; i++) @(posedge clk);
    if (sb2.size() != 0) begin
      chk("drain32_timeout", 64'(sb2.size()), 64'd0);
      sb2.delete();
    end
  endtask

  initial begin
    reset = 0; start = 0; sop = 0; x = 0; y = 0;
    start2 = 0; sop2 = 0; x2 = 0; y2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", 64'({hi, lo}), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy32", 64'(busy2), 64'd0);
    reset = 1;
    op(1, 8'hFD, 8'h07, 16'hFFEB, 0, 10);
    op(0, 8'hFF, 8'hFF, 16'hFE01, 1, 10);
    op(1, 8'hFF, 8'hFF, 16'h0001, 0, 10);
    op(1, 8'h80, 8'h80, 16'h4000, 1, 10);
    op(1, 8'h05, 8'hFC, 16'hFFEC, 0, 10);
    op(0, 8'h00, 8'h55, 16'h0000, 0, ZLAT);
    op(1, 8'h55, 8'h00, 16'h0000, 0, ZLAT);
    op(0, 8'h0F, 8'h0F, 16'h00E1, 0, 10);
    op(1, 8'h7F, 8'h7F, 16'h3F01, 1, 10);
    // A start pulse in the middle of CALC must be dropped, not queued.
    launch(1, 8'h03, 8'hFD, 16'hFFF7, 0, 10);
    repeat (2) @(negedge clk);
    chk("busy_calc", 64'(busy), 64'd1);
    start = 1; sop = 0; x = 8'h11; y = 8'h11;
    @(negedge clk);
    start = 0;
    drain();
    repeat (15) @(posedge clk);
    #1;
    chk("idle_after", 64'(busy), 64'd0);
    launch(0, 8'h07, 8'h09, 16'h003F, 0, 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    sb.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", 64'({hi, lo}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle", 64'(busy), 64'd0);
    op(1, 8'hFE, 8'h03, 16'hFFFA, 0, 10);
    op32(1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
    op32(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
